stw_col_checker: RTL

- Per-column BIST sequencer for a weight-stationary systolic column.
- Runs one stationary-test-weight (STW) pass per row and compares the column output against a golden product.
- Produces the per-row pass mask and completion flag that the column's BISR proxy controller consumes; it is the producer end of the STW_complete / STW_result_mat interface.
- One instance per column, placed beside the array edge.

---
 rtl/stw_col_checker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/stw_col_checker.sv
// Per-column STW BIST sequencer: load a test weight into each row, drive the test activation, check the column output.
// Optional STW_STICKY_FAULT_EN: the pass mask accumulates across runs and only rst restores it.
module stw_col_checker #(
    parameter int                   ROWS        = 4,
    parameter int                   WORD_SIZE   = 16,
    parameter logic [WORD_SIZE-1:0] TEST_WEIGHT = 16'd3,
    parameter logic [WORD_SIZE-1:0] TEST_ACT    = 16'd5,
    parameter int                   PIPE_LAT    = 5,
    localparam int                  RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WORD_SIZE-1:0]      col_output,
    output logic                      stw_weight_load,
    output logic [RW-1:0]             stw_weight_row_sel,
    output logic [WORD_SIZE-1:0]      stw_weight_out,
    output logic [ROWS*WORD_SIZE-1:0] stw_left_in,
    output logic                      set_stationary_mode,
    output logic                      matmul_mode,
    output logic                      busy,
    output logic                      STW_complete,
    output logic [ROWS-1:0]           STW_result_mat
);

    localparam int WW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(PIPE_LAT - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [2*WORD_SIZE-1:0] PRODUCT = TEST_ACT * TEST_WEIGHT;
    localparam logic [WORD_SIZE-1:0] EXPECTED = PRODUCT[WORD_SIZE-1:0];

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRIVE = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [RW-1:0]           cur_row_q, cur_row_d;
    logic [RW-1:0]           load_cnt_q, load_cnt_d;
    logic [WW-1:0]           wait_cnt_q, wait_cnt_d;
    logic [ROWS-1:0]         mask_q, mask_d;

    logic                    stw_weight_load_q, stw_weight_load_d;
    logic [RW-1:0]           stw_weight_row_sel_q, stw_weight_row_sel_d;
    logic [WORD_SIZE-1:0]    stw_weight_out_q, stw_weight_out_d;
    logic [ROWS*WORD_SIZE-1:0] stw_left_in_q, stw_left_in_d;
    logic                    set_stationary_mode_q, set_stationary_mode_d;
    logic                    matmul_mode_q, matmul_mode_d;
    logic                    busy_q, busy_d;
    logic                    stw_complete_q, stw_complete_d;

    logic                    row_pass;
    assign row_pass = (col_output == EXPECTED);

    // State register (also holds counters, mask and registered outputs)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q               <= IDLE;
            cur_row_q             <= '0;
            load_cnt_q            <= '0;
            wait_cnt_q            <= '0;
            mask_q                <= '1;
            stw_weight_load_q     <= 1'b0;
            stw_weight_row_sel_q  <= '0;
            stw_weight_out_q      <= '0;
            stw_left_in_q         <= '0;
            set_stationary_mode_q <= 1'b0;
            matmul_mode_q         <= 1'b0;
            busy_q                <= 1'b0;
            stw_complete_q        <= 1'b0;
        end else begin
            state_q               <= state_d;
            cur_row_q             <= cur_row_d;
            load_cnt_q            <= load_cnt_d;
            wait_cnt_q            <= wait_cnt_d;
            mask_q                <= mask_d;
            stw_weight_load_q     <= stw_weight_load_d;
            stw_weight_row_sel_q  <= stw_weight_row_sel_d;
            stw_weight_out_q      <= stw_weight_out_d;
            stw_left_in_q         <= stw_left_in_d;
            set_stationary_mode_q <= set_stationary_mode_d;
            matmul_mode_q         <= matmul_mode_d;
            busy_q                <= busy_d;
            stw_complete_q        <= stw_complete_d;
        end
    end

    // Next-state and counter/mask update
    always_comb begin
        state_d    = state_q;
        cur_row_d  = cur_row_q;
        load_cnt_d = load_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mask_d     = mask_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    cur_row_d  = '0;
                    load_cnt_d = '0;
`ifndef STW_STICKY_FAULT_EN
                    mask_d     = '1;
`endif
                end
            end
            LOAD: begin
                if (load_cnt_q == ROW_LAST) begin
                    state_d = DRIVE;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            DRIVE: begin
                wait_cnt_d = WW'(1);
                state_d    = (PIPE_LAT == 1) ? CHECK : WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            CHECK: begin
`ifdef STW_STICKY_FAULT_EN
                mask_d[cur_row_q] = mask_q[cur_row_q] & row_pass;
`else
                mask_d[cur_row_q] = row_pass;
`endif
                if (cur_row_q == ROW_LAST) begin
                    state_d = DONE;
                end else begin
                    cur_row_d  = cur_row_q + 1'b1;
                    load_cnt_d = '0;
                    state_d    = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register on that edge
    always_comb begin
        stw_weight_load_d     = (state_d == LOAD);
        set_stationary_mode_d = (state_d == LOAD);
        stw_weight_row_sel_d  = '0;
        stw_weight_out_d      = '0;
        stw_left_in_d         = '0;
        matmul_mode_d         = (state_d == DRIVE) || (state_d == WAIT) || (state_d == CHECK);
        busy_d                = (state_d != IDLE) && (state_d != DONE);
        stw_complete_d        = (state_d == DONE);
        if (state_d == LOAD) begin
            stw_weight_row_sel_d = load_cnt_d;
            if (load_cnt_d == cur_row_d) begin
                stw_weight_out_d = TEST_WEIGHT;
            end
        end
        if (state_d == DRIVE) begin
            for (int r = 0; r < ROWS; r++) begin
                if (RW'(r) == cur_row_d) begin
                    stw_left_in_d[r*WORD_SIZE +: WORD_SIZE] = TEST_ACT;
                end
            end
        end
    end

    assign stw_weight_load     = stw_weight_load_q;
    assign stw_weight_row_sel  = stw_weight_row_sel_q;
    assign stw_weight_out      = stw_weight_out_q;
    assign stw_left_in         = stw_left_in_q;
    assign set_stationary_mode = set_stationary_mode_q;
    assign matmul_mode         = matmul_mode_q;
    assign busy                = busy_q;
    assign STW_complete        = stw_complete_q;
    assign STW_result_mat      = mask_q;

endmodule
